// File: rtl/serial_add_driver.sv
// Sequencer for a WIDTH-bit serial adder: serialises an operand pair LSB first, then captures the s_out stream as a parallel sum.
// Optional macro SERIAL_ADD_DRV_CLEAR_EN adds a one-cycle CLEAR (clear_b low) ahead of LOAD_A.
module serial_add_driver #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             s_in,
    output logic             shift_ctrl,
    output logic             clear_b,
    input  logic             s_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef SERIAL_ADD_DRV_CLEAR_EN
    typedef enum logic [2:0] {IDLE, CLEAR, LOAD_A, LOAD_B, ADD, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, ADD, DONE} state_t;
`endif

    state_t           state_reg, state_next;
    logic [CW-1:0]    phase_reg;
    logic [WIDTH-1:0] a_sh_reg, b_sh_reg, sum_sh_reg, sum_out_reg;
    logic             out_valid_reg;
    logic             phase_last;
    logic             shifting;
    logic [WIDTH-1:0] sum_sh_next;

    assign phase_last  = (phase_reg == CW'(WIDTH - 1));
    assign shifting    = (state_reg == LOAD_A) || (state_reg == LOAD_B) || (state_reg == ADD);
    assign sum_sh_next = {s_out, sum_sh_reg[WIDTH-1:1]};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
`ifdef SERIAL_ADD_DRV_CLEAR_EN
                    state_next = CLEAR;
`else
                    state_next = LOAD_A;
`endif
                end
            end
`ifdef SERIAL_ADD_DRV_CLEAR_EN
            CLEAR:  state_next = LOAD_A;
`endif
            LOAD_A: if (phase_last) state_next = LOAD_B;
            LOAD_B: if (phase_last) state_next = ADD;
            ADD:    if (phase_last) state_next = DONE;
            DONE:   if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            phase_reg     <= '0;
            a_sh_reg      <= '0;
            b_sh_reg      <= '0;
            sum_sh_reg    <= '0;
            sum_out_reg   <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && in_valid) begin
                a_sh_reg <= a_in;
                b_sh_reg <= b_in;
            end
            if (state_reg == LOAD_A) a_sh_reg <= a_sh_reg >> 1;
            if (state_reg == LOAD_B) b_sh_reg <= b_sh_reg >> 1;
            if (state_reg == ADD)    sum_sh_reg <= sum_sh_next;
            if (shifting) phase_reg <= phase_last ? '0 : phase_reg + 1'b1;
            // The last ADD bit is folded in directly so sum_out carries the full stream
            if (state_reg == ADD && phase_last) begin
                sum_out_reg   <= sum_sh_next;
                out_valid_reg <= 1'b1;
            end
            if (state_reg == DONE && out_ready) out_valid_reg <= 1'b0;
        end
    end

    assign in_ready   = (state_reg == IDLE) && !rst;
    assign shift_ctrl = shifting;
    assign s_in       = (state_reg == LOAD_A) ? a_sh_reg[0] :
                        (state_reg == LOAD_B) ? b_sh_reg[0] : 1'b0;
`ifdef SERIAL_ADD_DRV_CLEAR_EN
    assign clear_b    = (state_reg != CLEAR);
`else
    assign clear_b    = 1'b1;
`endif
    assign sum_out    = sum_out_reg;
    assign out_valid  = out_valid_reg;
endmodule

// File: tb/tb_serial_add_driver.sv
// Scoreboard bench for serial_add_driver: the driver pushes expected sums, a negedge monitor pops them on each output handshake.
module tb_serial_add_driver;
    localparam int W = 4;
`ifdef SERIAL_ADD_DRV_CLEAR_EN
    localparam int C = 1;
`else
    localparam int C = 0;
`endif
    localparam int LAT = 3 * W + C;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         s_in, shift_ctrl, clear_b;
    logic         s_out = 1'b0;
    logic [W-1:0] sum_out;
    logic         out_valid;
    logic         out_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;
    logic prev_valid = 1'b0;
    logic [W-1:0] exp_q[$];

    serial_add_driver #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .s_in(s_in), .shift_ctrl(shift_ctrl),
        .clear_b(clear_b), .s_out(s_out), .sum_out(sum_out),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: latency on out_valid rise, sum on each accepted output
    always @(negedge clk) begin
        if (out_valid && !prev_valid) check("latency", cyc - accept_cyc, LAT);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_output", 1, 0);
            else check("sum_out", {28'd0, sum_out}, {28'd0, exp_q.pop_front()});
            $display("out: sum_out=%b at cycle %0d", sum_out, cyc);
        end
        prev_valid = out_valid;
    end

    // Accept an operand pair and walk the serial phases; stops in the first DONE cycle.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] sum, input int stop_k, output bit done);
        int bad_clr, bad_sh, bad_sin;
        bad_clr = 0; bad_sh = 0; bad_sin = 0; done = 1'b0;
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        a_in = a; b_in = b; in_valid = 1'b1;
        if (stop_k == 0) exp_q.push_back(sum);
        @(negedge clk);
        in_valid = 1'b0;
        accept_cyc = cyc;
        $display("in: a=%b b=%b expect sum=%b", a, b, sum);
        for (int k = 1; k <= LAT; k++) begin
            logic e_clr, e_sh, e_sin;
            e_clr = (k <= C) ? 1'b0 : 1'b1;
            e_sh  = (k > C);
            e_sin = 1'b0;
            if (k > C && k <= C + W)          e_sin = a[k - C - 1];
            else if (k > C + W && k <= C + 2*W) e_sin = b[k - C - W - 1];
            if (clear_b !== e_clr) bad_clr++;
            if (shift_ctrl !== e_sh) bad_sh++;
            if (s_in !== e_sin) bad_sin++;
            if (k == stop_k) begin
                check("clear_b_seq", bad_clr, 0);
                check("shift_ctrl_seq", bad_sh, 0);
                check("s_in_seq", bad_sin, 0);
                return;
            end
            s_out = (k > C + 2*W) ? sum[k - C - 2*W - 1] : 1'b0;
            @(negedge clk);
        end
        s_out = 1'b0;
        check("clear_b_seq", bad_clr, 0);
        check("shift_ctrl_seq", bad_sh, 0);
        check("s_in_seq", bad_sin, 0);
        check("done_shift_off", {shift_ctrl, s_in}, 0);
        check("done_valid", out_valid, 1);
        done = 1'b1;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] sum, input int hold);
        bit done;
        int bad_hold;
        start_op(a, b, sum, 0, done);
        bad_hold = 0;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            a_in = ~a; b_in = ~b;
            if (out_valid !== 1'b1 || sum_out !== sum || in_ready !== 1'b0) bad_hold++;
            @(negedge clk);
        end
        if (hold > 0) check("backpressure_hold", bad_hold, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("back_to_idle", {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        bit done;
        int bad_quiet;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_s_in", s_in, 0);
        check("rst_shift_ctrl", shift_ctrl, 0);
        check("rst_clear_b", clear_b, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum_out", sum_out, 0);
        check("rst_in_ready", in_ready, 1);

        run_op(4'b1010, 4'b0011, 4'b1101, 5);
        run_op(4'b1111, 4'b0001, 4'b0000, 0);
        run_op(4'b0110, 4'b0101, 4'b1011, 1);

        // Abort in the second LOAD_B cycle
        start_op(4'b1100, 4'b0110, 4'b0000, C + W + 2, done);
        rst = 1'b1;
        @(negedge clk);
        check("abort_shift_ctrl", shift_ctrl, 0);
        check("abort_s_in", s_in, 0);
        rst = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1);
        bad_quiet = 0;
        for (int i = 0; i < LAT + 3; i++) begin
            if (out_valid !== 1'b0 || shift_ctrl !== 1'b0) bad_quiet++;
            @(negedge clk);
        end
        check("abort_quiet", bad_quiet, 0);

        run_op(4'b0001, 4'b1000, 4'b1001, 2);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
